// File: rtl/s_acc17_seq.sv
// s_acc17_seq: frame accumulator for signed adder sums with valid/ready in/out; S_ACC_SAT_EN selects saturation over wrap
module s_acc17_seq #(
  parameter int IN_W = 17,
  parameter int ACC_W = 24,
  parameter int N_SAMPLES = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] out_data,
  output logic                    out_sat
);
  localparam int CW = $clog2(N_SAMPLES + 1);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t state, state_nx;
  logic signed [ACC_W-1:0] acc, acc_nx, add_res;
  logic [CW-1:0] count, count_nx;
  logic sat, sat_nx, ovf, last;
`ifdef S_ACC_SAT_EN
  logic signed [ACC_W:0] sum;
  assign sum = (ACC_W+1)'(acc) + (ACC_W+1)'(in_data);
  assign ovf = sum[ACC_W] ^ sum[ACC_W-1];
  // the extra top bit carries the true sign, so it picks the clamp rail
  assign add_res = !ovf ? sum[ACC_W-1:0] :
                   sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
`else
  assign ovf = 1'b0;
  assign add_res = acc + ACC_W'(in_data);
`endif
  assign last = count == CW'(N_SAMPLES - 1);
  assign in_ready = state == ACCUM;
  assign out_valid = state == HOLD;
  assign out_data = acc;
  assign out_sat = sat;
  always_comb begin
    state_nx = state;
    acc_nx = acc;
    count_nx = count;
    sat_nx = sat;
    if (clear) begin
      state_nx = ACCUM;
      acc_nx = '0;
      count_nx = '0;
      sat_nx = 1'b0;
    end else if (state == ACCUM) begin
      if (in_valid) begin
        acc_nx = add_res;
        sat_nx = sat | ovf;
        count_nx = last ? '0 : count + 1'b1;
        state_nx = last ? HOLD : ACCUM;
      end
    end else if (out_ready) begin
      acc_nx = '0;
      sat_nx = 1'b0;
      state_nx = ACCUM;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ACCUM;
      acc <= '0;
      count <= '0;
      sat <= 1'b0;
    end else begin
      state <= state_nx;
      acc <= acc_nx;
      count <= count_nx;
      sat <= sat_nx;
    end
  end
endmodule

// File: tb/tb_s_acc17_seq.sv
// tb_s_acc17_seq: directed checks of s_acc17_seq at N_SAMPLES=4 with ACC_W=24 and ACC_W=18 instances
module tb_s_acc17_seq;
  logic clk = 1'b0, rst = 1'b1, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic signed [16:0] in_data = '0;
  logic ir, ov, os, ir18, ov18, os18;
  logic signed [23:0] od;
  logic signed [17:0] od18;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  s_acc17_seq #(.IN_W(17), .ACC_W(24), .N_SAMPLES(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir), .in_data(in_data),
    .out_valid(ov), .out_ready(out_ready), .out_data(od), .out_sat(os));
  s_acc17_seq #(.IN_W(17), .ACC_W(18), .N_SAMPLES(4)) dut18 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(ir18), .in_data(in_data),
    .out_valid(ov18), .out_ready(out_ready), .out_data(od18), .out_sat(os18));
  task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic feed(input logic signed [16:0] v);
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b1;
    in_data = v;
  endtask
  task automatic idle();
    @(negedge clk);
    clear = 1'b0;
    in_valid = 1'b0;
  endtask
  initial begin
    in_valid = 1'b1;
    in_data = 17'sd5;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rst_out_valid", ov, 0);
    chk("rst_out_data", od, 0);
    chk("rst_out_sat", os, 0);
    chk("rst_in_ready", ir, 1);
    // basic frame, consumer always ready
    feed(100); feed(-50); feed(7); feed(3);
    idle();
    chk("basic_out_valid", ov, 1);
    chk("basic_out_data", od, 60);
    chk("basic_out_sat", os, 0);
    chk("basic_in_ready", ir, 0);
    idle();
    chk("basic_one_cycle", ov, 0);
    chk("basic_ready_back", ir, 1);
    // backpressure with upstream still offering data
    out_ready = 1'b0;
    feed(1); feed(2); feed(3); feed(4);
    for (int i = 0; i < 5; i++) begin
      feed(99);
      chk("bp_out_valid", ov, 1);
      chk("bp_out_data", od, 10);
      chk("bp_in_ready", ir, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle();
    chk("bp_release_valid", ov, 0);
    chk("bp_release_ready", ir, 1);
    feed(2); feed(2); feed(2); feed(2);
    idle();
    chk("bp_next_frame", od, 8);
    idle();
    // overflow on the 18-bit instance
    feed(65534); feed(65534); feed(65534); feed(65534);
    idle();
    chk("ovf18_valid", ov18, 1);
`ifdef S_ACC_SAT_EN
    chk("ovf18_data", od18, 131071);
    chk("ovf18_sat", os18, 1);
`else
    chk("ovf18_data", od18, -8);
    chk("ovf18_sat", os18, 0);
`endif
    chk("ovf24_data", od, 262136);
    chk("ovf24_sat", os, 0);
    idle();
    chk("ovf18_sat_cleared", os18, 0);
    // clear mid-frame drops the concurrent sample
    feed(5); feed(5);
    @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 17'sd9;
    idle();
    chk("clr_in_ready", ir, 1);
    chk("clr_out_valid", ov, 0);
    feed(1); feed(1); feed(1);
    idle();
    chk("clr_no_early_hold", ov, 0);
    feed(1);
    idle();
    chk("clr_out_valid_end", ov, 1);
    chk("clr_out_data", od, 4);
    idle();
    // negative extreme inputs
    feed(-65536); feed(-65536); feed(-65536); feed(-65536);
    idle();
    chk("neg_out_valid", ov, 1);
    chk("neg_out_data", od, -262144);
    chk("neg_out_sat", os, 0);
    idle();
    // clear while holding discards the total
    out_ready = 1'b0;
    feed(3); feed(3); feed(3); feed(3);
    idle();
    chk("hold_before_clear", ov, 1);
    @(negedge clk);
    clear = 1'b1;
    idle();
    chk("hold_cleared_valid", ov, 0);
    chk("hold_cleared_ready", ir, 1);
    out_ready = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
